// File: rtl/mirfak_wb_ram_slave.sv
// Wishbone classic slave in front of a word-organised RAM with byte-lane writes.
// One address window, programmable wait states, one ack/err pulse per accepted request.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | waiting for cyc&stb; accepts, latches the request, decodes the window
// ST_WAIT | down-counting wait states; access happens when the counter reaches 1
// ST_RESP | ack (hit) or err (miss) is high for this cycle, then back to idle
module mirfak_wb_ram_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] wbs_addr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);

   localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   logic [31:0]           mem [DEPTH];

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [31:0]           lat_dat;
   logic [3:0]            lat_sel;
   logic                  lat_we;

   logic                  req;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] in_idx;
   logic                  start_access;
   logic                  wait_access;
   logic                  do_access;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [31:0]           acc_dat;
   logic [3:0]            acc_sel;
   logic                  acc_we;
   logic                  unused_addr_bits;

   // Byte offset is the master's concern; only word granularity matters here.
   assign unused_addr_bits = ^wbs_addr_i[1:0];

   always_comb begin
      req          = wbs_cyc_i && wbs_stb_i;
      hit          = (wbs_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
      in_idx       = wbs_addr_i[ADDR_WIDTH+1:2];
      start_access = (state == ST_IDLE) && req && hit && (WAIT_STATES == 0);
      wait_access  = (state == ST_WAIT) && wbs_cyc_i && (cnt == 4'd1);
      do_access    = start_access || wait_access;
      // Zero-wait accesses happen in the accept cycle, so they use the live bus.
      if (state == ST_IDLE) begin
         acc_idx = in_idx;
         acc_dat = wbs_dat_i;
         acc_sel = wbs_sel_i;
         acc_we  = wbs_we_i;
      end else begin
         acc_idx = lat_idx;
         acc_dat = lat_dat;
         acc_sel = lat_sel;
         acc_we  = lat_we;
      end
      mem_we = do_access && acc_we && rst_ni;
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_sel[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         lat_idx   <= '0;
         lat_dat   <= 32'd0;
         lat_sel   <= 4'd0;
         lat_we    <= 1'b0;
         wbs_dat_o <= 32'd0;
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
      end else begin
         wbs_ack_o <= do_access;
         wbs_err_o <= (state == ST_IDLE) && req && !hit;
         if (do_access && !acc_we) begin
            wbs_dat_o <= mem[acc_idx];
         end
         case (state)
            ST_IDLE: begin
               if (req) begin
                  lat_idx <= in_idx;
                  lat_dat <= wbs_dat_i;
                  lat_sel <= wbs_sel_i;
                  lat_we  <= wbs_we_i;
                  if (!hit || (WAIT_STATES == 0)) begin
                     state <= ST_RESP;
                  end else begin
                     cnt   <= WAIT_CNT;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!wbs_cyc_i) begin
                  cnt   <= 4'd0;
                  state <= ST_IDLE;
               end else if (cnt == 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mirfak_wb_ram_slave.sv
// Bench for mirfak_wb_ram_slave: four instances (1, 3, 0 and 15 wait states), each on its
// own bus, checked against a lane-mask memory model and latency rules kept in the bench.
module tb_mirfak_wb_ram_slave;

   logic        clk;
   logic        rst_ni;
   logic [31:0] adr [4];
   logic [31:0] dat [4];
   logic [3:0]  sel [4];
   logic        cyc [4];
   logic        stb [4];
   logic        we  [4];
   logic [31:0] rdo [4];
   logic        ack [4];
   logic        err [4];

   int total;
   int bad;
   int cycle_cnt;

   logic [31:0] ref_mem [4][1024];
   bit          ref_ok  [4][1024];
   logic [31:0] ref_dat [4];

   int          lat;
   logic        g_ack;
   logic        g_err;
   logic        g_both;
   logic [31:0] rd;
   logic        extra;
   int          t_ack;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   mirfak_wb_ram_slave #(.WAIT_STATES(1)) u_ws1 (
      .clk_i(clk), .rst_ni(rst_ni), .wbs_addr_i(adr[0]), .wbs_dat_i(dat[0]),
      .wbs_sel_i(sel[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
      .wbs_dat_o(rdo[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));
   mirfak_wb_ram_slave #(.WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .rst_ni(rst_ni), .wbs_addr_i(adr[1]), .wbs_dat_i(dat[1]),
      .wbs_sel_i(sel[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
      .wbs_dat_o(rdo[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));
   mirfak_wb_ram_slave #(.WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .rst_ni(rst_ni), .wbs_addr_i(adr[2]), .wbs_dat_i(dat[2]),
      .wbs_sel_i(sel[2]), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]), .wbs_we_i(we[2]),
      .wbs_dat_o(rdo[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));
   mirfak_wb_ram_slave #(.WAIT_STATES(15)) u_ws15 (
      .clk_i(clk), .rst_ni(rst_ni), .wbs_addr_i(adr[3]), .wbs_dat_i(dat[3]),
      .wbs_sel_i(sel[3]), .wbs_cyc_i(cyc[3]), .wbs_stb_i(stb[3]), .wbs_we_i(we[3]),
      .wbs_dat_o(rdo[3]), .wbs_ack_o(ack[3]), .wbs_err_o(err[3]));

   function automatic int ws_of(input int k);
      case (k)
         0: return 1;
         1: return 3;
         2: return 0;
         default: return 15;
      endcase
   endfunction

   function automatic void model_write(input int k, input int idx, input logic [31:0] d,
                                       input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      ref_mem[k][idx] = (ref_mem[k][idx] & ~mask) | (d & mask);
      ref_ok[k][idx]  = 1'b1;
   endfunction

   // Called just after a rising edge; returns just after the edge that ends the response cycle,
   // leaving cyc/stb asserted so the caller may chain a back-to-back request.
   task automatic do_xfer(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
      lat = -1; g_ack = 1'b0; g_err = 1'b0; g_both = 1'b0; rd = 32'd0; extra = 1'b0; t_ack = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ack[k] || err[k]) begin
            lat    = c;
            g_ack  = ack[k];
            g_err  = err[k];
            g_both = ack[k] && err[k];
            rd     = rdo[k];
            t_ack  = cycle_cnt;
            break;
         end
      end
      @(posedge clk); #1;
      extra = ack[k] | err[k];
   endtask

   task automatic bus_idle(input int k);
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdo[k] !== 32'd0) begin
            bad++;
            $display("FAIL reset_init[%0d]: ack=%b err=%b dat=%h want 0 0 0", k, ack[k], err[k], rdo[k]);
         end
      end
      do_xfer(0, 1'b1, 32'h8000_0040, 32'hA5A5_1234, 4'hF);
      model_write(0, 16, 32'hA5A5_1234, 4'hF);
      bus_idle(0);
      do_xfer(1, 1'b1, 32'h8000_0044, 32'h600D_CAFE, 4'hF);
      model_write(1, 17, 32'h600D_CAFE, 4'hF);
      bus_idle(1);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h8000_0040; sel[0] = 4'hF;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h8000_0044;
      dat[1] = 32'hFFFF_0000; sel[1] = 4'hF;
      @(negedge clk); @(negedge clk); @(negedge clk);
      total++;
      if (ack[0] !== 1'b1 || rdo[0] !== 32'hA5A5_1234) begin
         bad++;
         $display("FAIL reset_pre: ack=%b dat=%h want 1 a5a51234", ack[0], rdo[0]);
      end
      #2 rst_ni = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      end
      #1;
      total++;
      if (ack[0] !== 1'b0 || err[0] !== 1'b0 || rdo[0] !== 32'd0 || ack[1] !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: ack0=%b err0=%b dat0=%h ack1=%b want 0 0 0 0",
                  ack[0], err[0], rdo[0], ack[1]);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      for (int k = 0; k < 4; k++) ref_dat[k] = 32'd0;
      g_ack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (ack[k] || err[k]) g_ack = 1'b1;
      end
      total++;
      if (g_ack !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_pulse: pulse seen=%b want 0", g_ack);
      end
      @(posedge clk); #1;
      do_xfer(1, 1'b0, 32'h8000_0044, 32'd0, 4'hF);
      ref_dat[1] = ref_mem[1][17];
      total++;
      if (lat !== 4 || rd !== 32'h600D_CAFE) begin
         bad++;
         $display("FAIL reset_discard: lat=%0d dat=%h want 4 600dcafe", lat, rd);
      end
      bus_idle(1);
   endtask

   task automatic test_word_rw;
      do_xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      model_write(0, 4, 32'hDEAD_BEEF, 4'hF);
      total++;
      if (lat !== 2 || g_ack !== 1'b1 || g_err !== 1'b0 || extra !== 1'b0 || rd !== ref_dat[0]) begin
         bad++;
         $display("FAIL word_wr: lat=%0d ack=%b err=%b next=%b dat=%h want 2 1 0 0 %h",
                  lat, g_ack, g_err, extra, rd, ref_dat[0]);
      end
      bus_idle(0);
      do_xfer(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0);
      ref_dat[0] = ref_mem[0][4];
      total++;
      if (lat !== 2 || g_ack !== 1'b1 || extra !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL word_rd: lat=%0d ack=%b next=%b dat=%h want 2 1 0 deadbeef", lat, g_ack, extra, rd);
      end
      bus_idle(0);
   endtask

   task automatic test_byte_lane;
      do_xfer(0, 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010);
      model_write(0, 4, 32'h0000_5500, 4'b0010);
      bus_idle(0);
      do_xfer(0, 1'b0, 32'h8000_0010, 32'd0, 4'b0001);
      ref_dat[0] = ref_mem[0][4];
      total++;
      if (lat !== 2 || rd !== 32'hDEAD_55EF) begin
         bad++;
         $display("FAIL byte_lane: lat=%0d dat=%h want 2 dead55ef", lat, rd);
      end
      bus_idle(0);
      do_xfer(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0000);
      bus_idle(0);
      do_xfer(0, 1'b0, 32'h8000_0010, 32'd0, 4'hF);
      total++;
      if (lat !== 2 || rd !== 32'hDEAD_55EF) begin
         bad++;
         $display("FAIL sel_zero: lat=%0d dat=%h want 2 dead55ef", lat, rd);
      end
      bus_idle(0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++) begin
         int          idx;
         logic        w;
         logic [31:0] d;
         logic [3:0]  s;
         logic [31:0] a;
         idx = $urandom_range(32, 63);
         w   = ($urandom_range(0, 1) == 1) || !ref_ok[0][idx];
         d   = $urandom;
         s   = ref_ok[0][idx] ? 4'($urandom_range(0, 15)) : 4'hF;
         a   = 32'h8000_0000 | (32'(idx) << 2) | 32'($urandom_range(0, 3));
         do_xfer(0, w, a, d, s);
         if (w) begin
            model_write(0, idx, d, s);
         end else begin
            ref_dat[0] = ref_mem[0][idx];
         end
         total++;
         if (lat !== 2 || g_ack !== 1'b1 || g_both !== 1'b0 || rd !== ref_dat[0]) begin
            bad++;
            $display("FAIL rand[%0d] we=%b idx=%0d: lat=%0d ack=%b both=%b dat=%h want 2 1 0 %h",
                     i, w, idx, lat, g_ack, g_both, rd, ref_dat[0]);
         end
         bus_idle(0);
      end
   endtask

   task automatic test_miss;
      logic [31:0] a;
      do_xfer(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
      total++;
      if (lat !== 1 || g_err !== 1'b1 || g_ack !== 1'b0 || extra !== 1'b0 || rd !== ref_dat[0]) begin
         bad++;
         $display("FAIL miss_wr: lat=%0d err=%b ack=%b next=%b dat=%h want 1 1 0 0 %h",
                  lat, g_err, g_ack, extra, rd, ref_dat[0]);
      end
      bus_idle(0);
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         if (a[31:12] == 20'h80000) a[31] = 1'b0;
         do_xfer(0, 1'($urandom_range(0, 1)), a, $urandom, 4'hF);
         total++;
         if (lat !== 1 || g_err !== 1'b1 || g_ack !== 1'b0 || rd !== ref_dat[0]) begin
            bad++;
            $display("FAIL miss_rand[%0d] a=%h: lat=%0d err=%b ack=%b dat=%h want 1 1 0 %h",
                     i, a, lat, g_err, g_ack, rd, ref_dat[0]);
         end
         bus_idle(0);
      end
      do_xfer(3, 1'b0, 32'h8000_1000, 32'd0, 4'hF);
      total++;
      if (lat !== 1 || g_err !== 1'b1 || g_ack !== 1'b0) begin
         bad++;
         $display("FAIL miss_ws15: lat=%0d err=%b ack=%b want 1 1 0", lat, g_err, g_ack);
      end
      bus_idle(3);
      for (int idx = 0; idx < 64; idx++) begin
         if (ref_ok[0][idx]) begin
            do_xfer(0, 1'b0, 32'h8000_0000 | (32'(idx) << 2), 32'd0, 4'hF);
            ref_dat[0] = ref_mem[0][idx];
            total++;
            if (lat !== 2 || rd !== ref_mem[0][idx]) begin
               bad++;
               $display("FAIL miss_ram[%0d]: lat=%0d dat=%h want 2 %h", idx, lat, rd, ref_mem[0][idx]);
            end
            bus_idle(0);
         end
      end
   endtask

   task automatic test_abort;
      do_xfer(1, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF);
      model_write(1, 8, 32'h0BAD_F00D, 4'hF);
      total++;
      if (lat !== 4 || g_ack !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre: lat=%0d ack=%b want 4 1", lat, g_ack);
      end
      bus_idle(1);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h8000_0020;
      dat[1] = 32'h1234_5678; sel[1] = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      g_ack = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ack[1] || err[1]) g_ack = 1'b1;
      end
      total++;
      if (g_ack !== 1'b0) begin
         bad++;
         $display("FAIL abort_pulse: pulse seen=%b want 0", g_ack);
      end
      @(posedge clk); #1;
      do_xfer(1, 1'b0, 32'h8000_0020, 32'd0, 4'hF);
      ref_dat[1] = ref_mem[1][8];
      total++;
      if (lat !== 4 || rd !== 32'h0BAD_F00D) begin
         bad++;
         $display("FAIL abort_mem: lat=%0d dat=%h want 4 0badf00d", lat, rd);
      end
      bus_idle(1);
   endtask

   task automatic test_back_to_back;
      int ks [3];
      int prev_t;
      ks = '{2, 1, 3};
      foreach (ks[j]) begin
         int k;
         int ws;
         k  = ks[j];
         ws = ws_of(k);
         for (int idx = 0; idx < 4; idx++) begin
            logic [31:0] d;
            d = $urandom;
            do_xfer(k, 1'b1, 32'h8000_0100 | (32'(idx) << 2), d, 4'hF);
            model_write(k, 64 + idx, d, 4'hF);
            total++;
            if (lat !== 1 + ws || g_ack !== 1'b1) begin
               bad++;
               $display("FAIL b2b_wr ws=%0d: lat=%0d ack=%b want %0d 1", ws, lat, g_ack, 1 + ws);
            end
            bus_idle(k);
         end
         prev_t = 0;
         for (int i = 0; i < 6; i++) begin
            int idx;
            idx = $urandom_range(0, 3);
            do_xfer(k, 1'b0, 32'h8000_0100 | (32'(idx) << 2), 32'd0, 4'hF);
            ref_dat[k] = ref_mem[k][64 + idx];
            total++;
            if (lat !== 1 + ws || rd !== ref_dat[k]) begin
               bad++;
               $display("FAIL b2b_rd ws=%0d #%0d: lat=%0d dat=%h want %0d %h",
                        ws, i, lat, rd, 1 + ws, ref_dat[k]);
            end
            if (i > 0) begin
               total++;
               if (t_ack - prev_t !== 2 + ws) begin
                  bad++;
                  $display("FAIL b2b_gap ws=%0d #%0d: gap=%0d want %0d", ws, i, t_ack - prev_t, 2 + ws);
               end
            end
            prev_t = t_ack;
         end
         bus_idle(k);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_ni = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
         adr[k] = 32'd0; dat[k] = 32'd0; sel[k] = 4'd0;
         ref_dat[k] = 32'd0;
      end
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_word_rw();
      test_byte_lane();
      test_random();
      test_miss();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mirfak_wb_ram_slave.md
# mirfak_wb_ram_slave

Wishbone classic (B3) slave wrapping a word-organised RAM with byte-lane writes. It is the responder for the core's data-port and instruction-port masters. It decodes one base-address window, inserts a configurable number of wait states, and answers every accepted request with exactly one `ack` or `err` pulse. Intended as the on-chip data/boot memory in the Mirfak SoC and in core-level testbenches.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. Size = 2^ADDR_WIDTH words (default 4 KiB).
- `BASE_ADDR`, default 32'h8000_0000: window base. Must be aligned to 2^(ADDR_WIDTH+2).
- `WAIT_STATES`, default 1: extra cycles before `ack`. Legal range 0..15.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `wbs_addr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_sel_i`  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
- `wbs_cyc_i`  in  1  bus cycle active.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  1 = write, 0 = read.
- `wbs_dat_o`  out  32  read data, registered.
- `wbs_ack_o`  out  1  transfer done, registered one-cycle pulse.
- `wbs_err_o`  out  1  transfer error, registered one-cycle pulse.

## Operation
- Request: `req = wbs_cyc_i && wbs_stb_i`.
- Hit: `wbs_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`.
- Word index: `wbs_addr_i[ADDR_WIDTH+1:2]`. Address bits [1:0] are ignored; alignment is checked by the master.
- Request latch: on acceptance, the block captures address, write data, select and `we` into registers. Inputs are not resampled until the next acceptance.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, no `req`: stay in IDLE.
  - IDLE, `req` and miss: go to RESP with the error flag set.
  - IDLE, `req`, hit, WAIT_STATES==0: perform the access, go to RESP.
  - IDLE, `req`, hit, WAIT_STATES>0: load the counter with WAIT_STATES, go to WAIT.
  - WAIT, `wbs_cyc_i` low: abort and return to IDLE. No write, no response.
  - WAIT, counter==1: perform the access, go to RESP.
  - WAIT, otherwise: decrement the counter.
  - RESP: `wbs_ack_o` (hit) or `wbs_err_o` (miss) is high for this single cycle, then go to IDLE unconditionally.
- Access, write: the latched data is written only to the lanes whose `sel` bit is 1; other lanes keep their old value. `sel`=4'b0000 is acked with no memory change.
- Access, read: the full word is loaded into `wbs_dat_o` regardless of `sel`. `wbs_dat_o` changes only on a read access and holds its value otherwise, including through writes and errors.
- A miss never touches memory or `wbs_dat_o`.
- `wbs_ack_o` and `wbs_err_o` are never high together.

## Timing
- Reset (`rst_ni` low, asynchronous): state IDLE, counter 0, `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=0. RAM contents are not reset.
- Reset mid-transfer: the pending response and any not-yet-performed write are discarded.
- Cycle 0 is the first cycle with `req` high in IDLE.
  - Hit: `ack` is high in cycle 1+WAIT_STATES.
  - Miss: `err` is high in cycle 1, independent of WAIT_STATES.
- Write data is visible to a read accepted in the cycle after `ack` or later.
- After RESP there is one mandatory IDLE cycle. The master still holds `stb` during the `ack` cycle, and that cycle is not taken as a new request. Minimum transfer period is 2+WAIT_STATES cycles.
- Master holds `cyc`/`stb` until `ack`/`err`, per the classic protocol. Deasserting `cyc` in RESP does not suppress the pulse.

## Test plan
- Reset: drive `rst_ni`=0 asynchronously mid-cycle. `ack`, `err` and `dat_o` go to 0 immediately, and no response pulse follows after release.
- Word write/read, WAIT_STATES=1:
  - Write 32'hDEAD_BEEF to 32'h8000_0010, sel=4'hF. `ack` is high in cycle 2 only.
  - Read the same address. `ack` is high in cycle 2 with `dat_o`=32'hDEAD_BEEF.
- Byte lane: after the above, write 32'h0000_5500 with sel=4'b0010. A read of the same address returns 32'hDEAD_55EF.
- Miss: write to 32'h0000_0000. `err` is high in cycle 1 for one cycle, `ack` never rises, and `dat_o` plus all RAM words are unchanged.
- Abort, WAIT_STATES=3: start a write to 32'h8000_0020, drop `cyc` in cycle 2. No `ack`/`err` is produced, and a later read shows the old contents.
- Latency sweep: WAIT_STATES ∈ {0, 3, 15} with back-to-back reads (master re-asserts `stb` immediately after `ack`).
  - `ack` arrives at cycle 1+WAIT_STATES.
  - Acks are spaced exactly 2+WAIT_STATES cycles apart.
